// File: rtl/ps2_rx_fifo.sv
// +--------------------------------------------------------------------+
// | ps2_rx_fifo : PS/2 device-to-host frame receiver with FWFT byte     |
// |               FIFO, sticky error flags and last-N-byte history.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ps2_rx_fifo #(
   parameter int SYNC_STAGES    = 2,
   parameter int FIFO_DEPTH     = 8,
   parameter int HIST_BYTES     = 3,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   input  logic                          iPS2CLK,
   input  logic                          iDATA,
   input  logic                          iREADY,
   input  logic                          iERR_CLR,
   output logic [7:0]                    oDATA,
   output logic                          oVALID,
   output logic [$clog2(FIFO_DEPTH):0]   oCOUNT,
   output logic [8*HIST_BYTES-1:0]       oHIST,
   output logic [3:0]                    oERR,
   output logic                          oBUSY
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(FIFO_DEPTH);
   localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
   localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
   localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT_CYCLES);
   localparam logic [c_TW-1:0] c_TMO_ONE = c_TW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   w_clk_s;
   logic                   w_dat_s;
   logic                   w_fe;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [2:0]             r_bitcnt;
   logic [7:0]             r_shift;
   logic                   r_par;
   logic [c_TW-1:0]        r_tmo;
   logic                   w_timeout;
   logic                   w_stop_fe;
   logic                   w_par_err;
   logic                   w_frm_err;
   logic                   r_push;

   logic [7:0]             r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]        r_wr;
   logic [c_AW-1:0]        r_rd;
   logic [c_CW-1:0]        r_count;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_wr;

   logic [3:0]             r_err;
   logic [3:0]             w_err_set;
   logic [8*HIST_BYTES-1:0] r_hist;

   // Synchronisers idle high so reset release never fakes a falling edge
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], iPS2CLK};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], iDATA};
         r_clk_prev <= w_clk_s;
      end
   end

   assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
   assign w_fe    = r_clk_prev & ~w_clk_s;

   assign w_timeout = (r_state != ST_IDLE) && (r_tmo == c_TMO_MAX);
   assign w_stop_fe = w_fe && (r_state == ST_STOP) && !w_timeout;
   assign w_par_err = ~(^{r_shift, r_par});
   assign w_frm_err = ~w_dat_s;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = ST_IDLE;
      end else if (w_fe) begin
         case (r_state)
            ST_IDLE:   if (!w_dat_s) w_state_nxt = ST_DATA;
            ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
            ST_PARITY: w_state_nxt = ST_STOP;
            ST_STOP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Frame datapath; r_shift stays stable through the push cycle
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_bitcnt <= 3'd0;
         r_shift  <= 8'h00;
         r_par    <= 1'b0;
         r_tmo    <= '0;
         r_push   <= 1'b0;
      end else begin
         r_push <= w_stop_fe && !w_par_err && !w_frm_err;
         if (r_state == ST_IDLE || w_fe) begin
            r_tmo <= '0;
         end else begin
            r_tmo <= r_tmo + c_TMO_ONE;
         end
         if (w_fe && !w_timeout) begin
            case (r_state)
               ST_IDLE: r_bitcnt <= 3'd0;
               ST_DATA: begin
                  r_shift  <= {w_dat_s, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
               end
               ST_PARITY: r_par <= w_dat_s;
               default: ;
            endcase
         end
      end
   end

   assign w_pop  = oVALID & iREADY;
   assign w_full = (r_count == c_DEPTH);
   assign w_wr   = r_push & (~w_full | w_pop);

   always_ff @(posedge iCLK) begin
      if (w_wr) begin
         r_mem[r_wr] <= r_shift;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)  r_wr <= r_wr + c_PTR_ONE;
         if (w_pop) r_rd <= r_rd + c_PTR_ONE;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_err_set = {r_push & w_full & ~w_pop,
                       w_timeout,
                       w_stop_fe & w_frm_err,
                       w_stop_fe & w_par_err};

   // Set beats clear when both land on the same bit
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_err <= 4'h0;
      end else begin
         r_err <= (r_err & ~{4{iERR_CLR}}) | w_err_set;
      end
   end

   generate
      if (HIST_BYTES == 1) begin : g_hist_one
         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N)     r_hist <= '0;
            else if (r_push) r_hist <= r_shift;
         end
      end else begin : g_hist_multi
         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N)     r_hist <= '0;
            else if (r_push) r_hist <= {r_hist[8*HIST_BYTES-9:0], r_shift};
         end
      end
   endgenerate

   assign oVALID = (r_count != '0);
   assign oDATA  = oVALID ? r_mem[r_rd] : 8'h00;
   assign oCOUNT = r_count;
   assign oHIST  = r_hist;
   assign oERR   = r_err;
   assign oBUSY  = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// +--------------------------------------------------------------------+
// | tb_ps2_rx_fifo : directed bench for ps2_rx_fifo (short timeout,     |
// |                  4-entry FIFO, fast PS/2 clock).                    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_rx_fifo;

   localparam int HALF = 20;
   localparam int TMO  = 200;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        ps2clk   = 1'b1;
   logic        ps2dat   = 1'b1;
   logic        ready    = 1'b0;
   logic        errclr   = 1'b0;
   logic [7:0]  o_data;
   logic        o_valid;
   logic [2:0]  o_count;
   logic [23:0] o_hist;
   logic [3:0]  o_err;
   logic        o_busy;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   ps2_rx_fifo #(
      .SYNC_STAGES   (2),
      .FIFO_DEPTH    (4),
      .HIST_BYTES    (3),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .iCLK    (clk),
      .iRST_N  (rst_n),
      .iPS2CLK (ps2clk),
      .iDATA   (ps2dat),
      .iREADY  (ready),
      .iERR_CLR(errclr),
      .oDATA   (o_data),
      .oVALID  (o_valid),
      .oCOUNT  (o_count),
      .oHIST   (o_hist),
      .oERR    (o_err),
      .oBUSY   (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // bits[0] is the start bit; device changes data while the clock is high
   task automatic ps2_send(input logic [10:0] bits, input int nbits);
      logic [10:0] b;
      b = bits;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2dat = b[i];
         idle(HALF);
         ps2clk = 1'b0;
         idle(HALF);
         ps2clk = 1'b1;
      end
      ps2dat = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] data, input logic par, input logic stop);
      ps2_send({stop, par, data, 1'b0}, 11);
      idle(10);
   endtask

   task automatic pop;
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
   endtask

   task automatic clr_err;
      @(negedge clk) errclr = 1'b1;
      @(negedge clk) errclr = 1'b0;
      idle(1);
   endtask

   initial begin
      // Reset state
      idle(3);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_data",  32'(o_data),  32'h00);
      check("rst_count", 32'(o_count), 32'h0);
      check("rst_hist",  32'(o_hist),  32'h0);
      check("rst_err",   32'(o_err),   32'h0);
      check("rst_busy",  32'(o_busy),  32'h0);
      @(negedge clk) rst_n = 1'b1;
      idle(5);

      // Good frame 0x1C
      send_byte(8'h1C, 1'b0, 1'b1);
      check("f1c_valid", 32'(o_valid),     32'h1);
      check("f1c_data",  32'(o_data),      32'h1C);
      check("f1c_count", 32'(o_count),     32'h1);
      check("f1c_hist",  32'(o_hist[7:0]), 32'h1C);
      check("f1c_err",   32'(o_err),       32'h0);
      pop();
      check("pop_valid", 32'(o_valid),     32'h0);
      check("pop_count", 32'(o_count),     32'h0);

      // Parity error, then framing error, then clear
      send_byte(8'h1C, 1'b1, 1'b1);
      check("perr_count", 32'(o_count), 32'h0);
      check("perr_err",   32'(o_err),   32'h1);
      send_byte(8'h1C, 1'b0, 1'b0);
      check("ferr_count", 32'(o_count), 32'h0);
      check("ferr_err",   32'(o_err),   32'h3);
      clr_err();
      check("clr_err", 32'(o_err), 32'h0);

      // Partial frame: start + 5 data bits, then the clock stalls
      ps2_send({3'b111, 8'h15, 1'b0}, 6);
      idle(5);
      check("tmo_busy_mid", 32'(o_busy), 32'h1);
      idle(TMO + 30);
      check("tmo_err",   32'(o_err),   32'h4);
      check("tmo_busy",  32'(o_busy),  32'h0);
      check("tmo_count", 32'(o_count), 32'h0);
      send_byte(8'hF0, 1'b1, 1'b1);
      check("after_tmo_data",  32'(o_data),  32'hF0);
      check("after_tmo_count", 32'(o_count), 32'h1);
      pop();
      clr_err();

      // History and FIFO ordering
      send_byte(8'hE0, 1'b0, 1'b1);
      send_byte(8'hF0, 1'b1, 1'b1);
      send_byte(8'h75, 1'b0, 1'b1);
      check("hist3",  32'(o_hist),  32'hE0F075);
      check("cnt3",   32'(o_count), 32'h3);
      check("seq0",   32'(o_data),  32'hE0);
      pop();
      check("seq1",   32'(o_data),  32'hF0);
      pop();
      check("seq2",   32'(o_data),  32'h75);
      pop();
      check("seq_empty", 32'(o_count), 32'h0);

      // Overflow: five frames into a 4-entry FIFO
      send_byte(8'h01, 1'b0, 1'b1);
      send_byte(8'h02, 1'b0, 1'b1);
      send_byte(8'h03, 1'b1, 1'b1);
      send_byte(8'h04, 1'b0, 1'b1);
      send_byte(8'h05, 1'b1, 1'b1);
      check("ovf_count", 32'(o_count),     32'h4);
      check("ovf_err",   32'(o_err),       32'h8);
      check("ovf_hist",  32'(o_hist[7:0]), 32'h05);
      check("ovf_d0", 32'(o_data), 32'h01);
      pop();
      check("ovf_d1", 32'(o_data), 32'h02);
      pop();
      check("ovf_d2", 32'(o_data), 32'h03);
      pop();
      check("ovf_d3", 32'(o_data), 32'h04);
      pop();
      check("ovf_empty", 32'(o_count), 32'h0);

      // Asynchronous reset mid-frame (start + 4 data bits)
      ps2_send({3'b111, 8'h0F, 1'b0}, 5);
      idle(2);
      check("pre_rst_busy", 32'(o_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",  32'(o_busy),  32'h0);
      check("arst_hist",  32'(o_hist),  32'h0);
      check("arst_err",   32'(o_err),   32'h0);
      check("arst_count", 32'(o_count), 32'h0);
      check("arst_valid", 32'(o_valid), 32'h0);
      idle(3);
      @(negedge clk) rst_n = 1'b1;
      idle(5);
      send_byte(8'h5A, 1'b1, 1'b1);
      check("f5a_data",  32'(o_data),  32'h5A);
      check("f5a_count", 32'(o_count), 32'h1);
      check("f5a_err",   32'(o_err),   32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
